// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, nmasters masters onto one slave port.
// Holds the grant for the whole time the owner's cyc is high (bursts included).
// A watchdog ends a strobe the slave never answers: it sends an error to the owner
// and parks the arbiter in ABORT until the owner drops cyc.
// Ports:
//   sys_clk, sys_rst                        clock, async active-high reset
//   m_adr_i/m_dat_i/m_cti_i/m_we_i/m_sel_i  packed per-master request fields, master i at slice i
//   m_cyc_i/m_stb_i                         per-master cycle/strobe
//   m_dat_o, m_ack_o, m_err_o               read data broadcast, owner-only ack/err
//   s_*                                     muxed slave port
//   grant_o, busy_o                         one-hot owner, state != IDLE
module wb_rr_arbiter #(
    parameter int unsigned nmasters  = 4,
    parameter int unsigned adr_width = 32,
    parameter int unsigned dat_width = 32,
    parameter int unsigned timeout   = 1024
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic [nmasters*adr_width-1:0]     m_adr_i,
    input  logic [nmasters*dat_width-1:0]     m_dat_i,
    output logic [dat_width-1:0]              m_dat_o,
    input  logic [nmasters*3-1:0]             m_cti_i,
    input  logic [nmasters-1:0]               m_we_i,
    input  logic [nmasters*(dat_width/8)-1:0] m_sel_i,
    input  logic [nmasters-1:0]               m_cyc_i,
    input  logic [nmasters-1:0]               m_stb_i,
    output logic [nmasters-1:0]               m_ack_o,
    output logic [nmasters-1:0]               m_err_o,
    output logic [adr_width-1:0]              s_adr_o,
    output logic [dat_width-1:0]              s_dat_o,
    input  logic [dat_width-1:0]              s_dat_i,
    output logic [2:0]                        s_cti_o,
    output logic                              s_we_o,
    output logic [dat_width/8-1:0]            s_sel_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    output logic [nmasters-1:0]               grant_o,
    output logic                              busy_o
);

    localparam int unsigned SEL_W = dat_width / 8;
    localparam int unsigned IDX_W = $clog2(nmasters);
    localparam int unsigned CNT_W = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((timeout > 0) ? timeout - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(nmasters - 1);

    typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    last_owner;   // doubles as the current owner index while not IDLE
    logic [IDX_W-1:0]    pick_idx;
    logic [nmasters-1:0] pick_oh;
    logic                pick_valid;
    logic                grant_load, grant_clear;
    logic [CNT_W-1:0]    wd_cnt;
    logic                owned, owner_cyc, owner_stb, wd_expire;

    assign owned     = (state == OWNED);
    assign owner_cyc = (state != IDLE) && m_cyc_i[last_owner];
    assign owner_stb = (state != IDLE) && m_stb_i[last_owner];
    // Owner dropping cyc in the expiry cycle, or any response, suppresses the abort.
    assign wd_expire = (timeout != 0) && owned && owner_cyc && owner_stb &&
                       !s_ack_i && !s_err_i && (wd_cnt == CNT_LAST);

    // Round-robin pick: search last_owner+1 .. last_owner (wrapping), first cyc wins.
    always_comb begin
        int unsigned cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        for (int unsigned k = 1; k <= nmasters; k++) begin
            cand = (32'(last_owner) + k) % nmasters;
            if (!pick_valid && m_cyc_i[cand]) begin
                pick_valid    = 1'b1;
                pick_idx      = IDX_W'(cand);
                pick_oh       = '0;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; a handover loads the new grant without passing through IDLE.
    always_comb begin
        state_next  = state;
        grant_load  = 1'b0;
        grant_clear = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = OWNED;
                    grant_load = 1'b1;
                end
            end
            OWNED: begin
                if (!owner_cyc) begin
                    if (pick_valid) begin
                        grant_load = 1'b1;
                    end else begin
                        state_next  = IDLE;
                        grant_clear = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_next = ABORT;
                end
            end
            ABORT: begin
                if (!owner_cyc) begin
                    state_next  = IDLE;
                    grant_clear = 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                grant_clear = 1'b1;
            end
        endcase
    end

    // Grant and owner registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant_o    <= '0;
            last_owner <= IDX_LAST;
        end else if (grant_load) begin
            grant_o    <= pick_oh;
            last_owner <= pick_idx;
        end else if (grant_clear) begin
            grant_o    <= '0;
        end
    end

    // Watchdog: counts unanswered strobe cycles of the current owner.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wd_cnt <= '0;
        end else if (!s_stb_o || s_ack_i || s_err_i || grant_load || wd_expire) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    // Output logic: request mux from the registered owner, responses gated to it.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_cti_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        if (state != IDLE) begin
            s_adr_o = m_adr_i[32'(last_owner)*adr_width +: adr_width];
            s_dat_o = m_dat_i[32'(last_owner)*dat_width +: dat_width];
            s_cti_o = m_cti_i[32'(last_owner)*3 +: 3];
            s_we_o  = m_we_i[last_owner];
            s_sel_o = m_sel_i[32'(last_owner)*SEL_W +: SEL_W];
        end
        s_cyc_o = owner_cyc && owned;
        s_stb_o = owner_stb && owned;
        m_dat_o = s_dat_i;
        m_ack_o = (s_ack_i && owned) ? grant_o : '0;
        m_err_o = ((s_err_i && owned) || wd_expire) ? grant_o : '0;
        busy_o  = (state != IDLE);
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: main instance with timeout=16, second with the
// watchdog disabled. Inputs change #1 after a rising edge; outputs checked #1 later.
module tb_wb_rr_arbiter;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic [127:0] m_adr_i, m_dat_i;
    logic [11:0]  m_cti_i;
    logic [3:0]   m_we_i, m_cyc_i, m_stb_i;
    logic [15:0]  m_sel_i;
    logic [31:0]  m_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]   m_ack_o, m_err_o, grant_o, s_sel_o;
    logic [2:0]   s_cti_o;
    logic         s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, busy_o;

    // watchdog-disabled instance
    logic         rst0;
    logic [3:0]   cyc0, stb0;
    logic [31:0]  m_dat_o0, s_adr_o0, s_dat_o0;
    logic [3:0]   m_ack_o0, m_err_o0, grant_o0, s_sel_o0;
    logic [2:0]   s_cti_o0;
    logic         s_we_o0, s_cyc_o0, s_stb_o0, busy_o0;

    int checks = 0;
    int errors = 0;
    int err0_seen = 0;

    always #5 sys_clk = ~sys_clk;

    wb_rr_arbiter #(.nmasters(4), .adr_width(32), .dat_width(32), .timeout(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_cti_i(m_cti_i),
        .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_cti_o(s_cti_o),
        .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o), .busy_o(busy_o)
    );

    wb_rr_arbiter #(.nmasters(4), .adr_width(32), .dat_width(32), .timeout(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(rst0),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o0), .m_cti_i(m_cti_i),
        .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_cyc_i(cyc0), .m_stb_i(stb0),
        .m_ack_o(m_ack_o0), .m_err_o(m_err_o0),
        .s_adr_o(s_adr_o0), .s_dat_o(s_dat_o0), .s_dat_i(s_dat_i), .s_cti_o(s_cti_o0),
        .s_we_o(s_we_o0), .s_sel_o(s_sel_o0), .s_cyc_o(s_cyc_o0), .s_stb_o(s_stb_o0),
        .s_ack_i(1'b0), .s_err_i(1'b0), .grant_o(grant_o0), .busy_o(busy_o0)
    );

    always @(negedge sys_clk) if (m_err_o0 != 4'b0) err0_seen++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input int i, input logic c, input logic s, input logic [2:0] cti,
                         input logic [31:0] adr);
        m_cyc_i[i]          = c;
        m_stb_i[i]          = s;
        m_cti_i[i*3 +: 3]   = cti;
        m_adr_i[i*32 +: 32] = adr;
    endtask

    initial begin
        logic [3:0] oh;
        sys_rst = 1'b1; rst0 = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_cti_i = '0; m_we_i = '0; m_sel_i = '0;
        m_cyc_i = '0; m_stb_i = '0; s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
        cyc0 = '0; stb0 = '0;
        #12;
        check("rst_grant", 64'(grant_o), 64'h0);
        check("rst_busy",  64'(busy_o), 64'h0);
        check("rst_scyc",  64'(s_cyc_o), 64'h0);
        check("rst_sadr",  64'(s_adr_o), 64'h0);
        check("rst_ack_err", 64'({m_ack_o, m_err_o}), 64'h0);
        next();
        sys_rst = 1'b0; rst0 = 1'b0;
        cyc0 = 4'b0001; stb0 = 4'b0001;

        // fairness: each owner does one acked beat, then drops cyc for one cycle
        m_cyc_i = 4'hF; m_stb_i = 4'hF;
        #1 check("fair_idle_grant", 64'(grant_o), 64'h0);
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << (n % 4);
            next();
            check($sformatf("fair_grant%0d", n), 64'(grant_o), 64'(oh));
            m_cyc_i = 4'hF; m_stb_i = 4'hF; s_ack_i = 1'b1;
            #1 check($sformatf("fair_ack%0d", n), 64'(m_ack_o), 64'(oh));
            next();
            s_ack_i = 1'b0; m_cyc_i = ~oh; m_stb_i = ~oh;
            #1 check($sformatf("fair_drop_scyc%0d", n), 64'(s_cyc_o), 64'h0);
        end
        next();
        check("fair_after", 64'(grant_o), 64'h2);
        m_cyc_i = '0; m_stb_i = '0;
        next();
        check("fair_idle_end", 64'(grant_o), 64'h0);

        // single master read of 0xDEADBEEF
        drive(0, 1'b1, 1'b1, 3'd0, 32'h0000_1000);
        m_sel_i[3:0] = 4'hF;
        #1 check("sm_pre_grant", 64'(grant_o), 64'h0);
        next();
        check("sm_grant", 64'(grant_o), 64'h1);
        check("sm_scyc_stb", 64'({s_cyc_o, s_stb_o}), 64'h3);
        check("sm_sadr", 64'(s_adr_o), 64'h1000);
        check("sm_ssel", 64'(s_sel_o), 64'hF);
        check("sm_busy", 64'(busy_o), 64'h1);
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1 check("sm_ack", 64'(m_ack_o), 64'h1);
        check("sm_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
        next();
        s_ack_i = 1'b0; drive(0, 1'b0, 1'b0, 3'd0, 32'h0);
        #1 check("sm_drop_scyc", 64'(s_cyc_o), 64'h0);
        check("sm_drop_grant", 64'(grant_o), 64'h1);
        next();
        check("sm_idle_grant", 64'(grant_o), 64'h0);
        check("sm_idle_busy", 64'(busy_o), 64'h0);
        check("sm_idle_sadr", 64'(s_adr_o), 64'h0);

        // burst lock: master 1 does a 4-beat burst while master 2 waits
        drive(1, 1'b1, 1'b1, 3'b010, 32'h0000_2000);
        drive(2, 1'b1, 1'b1, 3'b000, 32'h0000_3000);
        next();
        for (int b = 0; b < 4; b++) begin
            drive(1, 1'b1, 1'b1, (b == 3) ? 3'b111 : 3'b010, 32'h2000 + 32'(4*b));
            s_ack_i = 1'b1;
            #1 check($sformatf("burst_grant%0d", b), 64'(grant_o), 64'h2);
            check($sformatf("burst_ack%0d", b), 64'(m_ack_o), 64'h2);
            check($sformatf("burst_cti%0d", b), 64'(s_cti_o), (b == 3) ? 64'h7 : 64'h2);
            next();
        end
        s_ack_i = 1'b0; drive(1, 1'b0, 1'b0, 3'd0, 32'h0);
        #1 check("burst_drop_scyc", 64'(s_cyc_o), 64'h0);
        next();
        check("handover_grant", 64'(grant_o), 64'h4);
        check("handover_scyc", 64'(s_cyc_o), 64'h1);
        check("handover_sadr", 64'(s_adr_o), 64'h3000);

        // watchdog: master 2 strobes, slave silent; err in the 16th strobe cycle
        check("wd_c1", 64'(m_err_o), 64'h0);
        for (int c = 2; c <= 16; c++) begin
            next();
            check($sformatf("wd_c%0d", c), 64'(m_err_o), (c == 16) ? 64'h4 : 64'h0);
        end
        next();
        check("wd_abort_cyc_stb", 64'({s_cyc_o, s_stb_o}), 64'h0);
        check("wd_abort_err", 64'(m_err_o), 64'h0);
        check("wd_abort_busy", 64'(busy_o), 64'h1);
        s_ack_i = 1'b1;
        #1 check("wd_late_ack", 64'(m_ack_o), 64'h0);
        next();
        s_ack_i = 1'b0; drive(2, 1'b0, 1'b0, 3'd0, 32'h0);
        next();
        check("wd_idle", 64'({grant_o, busy_o}), 64'h0);

        // ack coincident with the 16th strobe cycle wins
        drive(3, 1'b1, 1'b1, 3'd0, 32'h0000_4000);
        next();
        check("co_grant", 64'(grant_o), 64'h8);
        repeat (15) next();
        s_ack_i = 1'b1;
        #1 check("co_ack", 64'(m_ack_o), 64'h8);
        check("co_no_err", 64'(m_err_o), 64'h0);
        next();
        s_ack_i = 1'b0;
        #1 check("co_still_owned", 64'({grant_o, s_cyc_o}), 64'h11);
        check("co_err_after", 64'(m_err_o), 64'h0);
        s_err_i = 1'b1;
        #1 check("serr_owner_only", 64'(m_err_o), 64'h8);
        check("serr_no_ack", 64'(m_ack_o), 64'h0);
        next();
        s_err_i = 1'b0; drive(3, 1'b0, 1'b0, 3'd0, 32'h0);
        next();
        check("serr_idle", 64'(grant_o), 64'h0);

        // async reset mid-burst, then master 0 wins when all request
        drive(1, 1'b1, 1'b1, 3'b010, 32'h0000_5000);
        next();
        check("rb_grant", 64'(grant_o), 64'h2);
        s_ack_i = 1'b1;
        #1 check("rb_ack", 64'(m_ack_o), 64'h2);
        #2 sys_rst = 1'b1;
        #1 check("rb_grant_rst", 64'(grant_o), 64'h0);
        check("rb_scyc_rst", 64'(s_cyc_o), 64'h0);
        check("rb_busy_ack_rst", 64'({busy_o, m_ack_o}), 64'h0);
        s_ack_i = 1'b0; m_cyc_i = 4'hF; m_stb_i = 4'hF;
        next();
        next();
        check("rb_held", 64'(grant_o), 64'h0);
        sys_rst = 1'b0;
        next();
        check("rb_first_m0", 64'(grant_o), 64'h1);
        m_cyc_i = '0; m_stb_i = '0;

        // watchdog disabled: an unanswered strobe is never aborted
        repeat (10000) next();
        check("nowd_err_count", 64'(err0_seen), 64'h0);
        check("nowd_still_owned", 64'({grant_o0, s_stb_o0}), 64'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
